// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Used by uart_rx_controller and uart_rx_edge_bit_counter.
package uart_rx_pkg;

    localparam int PRESCALE_W = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // Per-frame configuration, captured while idle and frozen until the frame ends
    typedef struct packed {
        logic                  par_en;
        logic                  par_typ;
        logic [PRESCALE_W-1:0] prescale;
    } rx_cfg_t;

    // Parity bit the transmitter should have sent for a payload whose XOR-reduction is data_xor
    function automatic logic exp_parity(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and data-bit counter for the UART receiver.
// bit_end marks the last oversample cycle of the current bit.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cnt_en,
    input  logic                  cnt_clear,
    input  logic                  bit_inc,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic                  bit_end,
    output logic                  last_bit
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [BIT_W-1:0] bit_count;

    assign bit_end  = cnt_en && (edge_count == prescale - PRESCALE_W'(1));
    assign last_bit = (bit_count == BIT_W'(DATA_W - 1));

    // Parked at zero while idle so a new start bit always begins at index 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            edge_count <= '0;
        else if (cnt_clear || !cnt_en || bit_end)
            edge_count <= '0;
        else
            edge_count <= edge_count + PRESCALE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bit_count <= '0;
        else if (cnt_clear)
            bit_count <= '0;
        else if (bit_inc)
            bit_count <= bit_count + BIT_W'(1);
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start detect, LSB-first deserialize, parity and stop checks.
// Optional build macro UART_RX_START_GLITCH_EN aborts frames whose start bit samples high.
module uart_rx_controller
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_data,
    output logic                  data_sampler_enable,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    rx_state_e         state, state_nxt;
    rx_cfg_t           cfg_q;
    logic [DATA_W-1:0] shift_q, shift_nxt;
    logic [DATA_W-1:0] p_data_nxt;
    logic              dv_nxt, perr_nxt, serr_nxt;
    logic              start_det, bit_end, last_bit;

    assign start_det = (state == ST_IDLE) && !RX_IN;

    uart_rx_edge_bit_counter #(
        .DATA_W (DATA_W)
    ) u_cnt (
        .clk        (clk_based_on_prescale),
        .rst_n      (rst_n),
        .cnt_en     (state != ST_IDLE),
        .cnt_clear  (start_det),
        .bit_inc    ((state == ST_DATA) && bit_end),
        .prescale   (cfg_q.prescale),
        .edge_count (edge_count),
        .bit_end    (bit_end),
        .last_bit   (last_bit)
    );

    // Config only follows the pins while idle; the edge that detects a start latches the frame's values
    always_ff @(posedge clk_based_on_prescale or negedge rst_n) begin
        if (!rst_n)
            cfg_q <= '0;
        else if (state == ST_IDLE)
            cfg_q <= '{par_en: PAR_EN, par_typ: PAR_TYP, prescale: prescale};
    end

    always_ff @(posedge clk_based_on_prescale or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!RX_IN) state_nxt = ST_START;
`ifdef UART_RX_START_GLITCH_EN
            ST_START:  if (bit_end) state_nxt = sampled_data ? ST_IDLE : ST_DATA;
`else
            ST_START:  if (bit_end) state_nxt = ST_DATA;
`endif
            ST_DATA:   if (bit_end && last_bit) state_nxt = cfg_q.par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_nxt = ST_STOP;
            ST_STOP:   if (bit_end) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_nxt  = shift_q;
        p_data_nxt = P_DATA;
        dv_nxt     = 1'b0;
        perr_nxt   = parity_error;
        serr_nxt   = stop_error;
        case (state)
            ST_IDLE: begin
                if (!RX_IN) begin
                    perr_nxt = 1'b0;
                    serr_nxt = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end)
                    shift_nxt = (shift_q >> 1) | (DATA_W'(sampled_data) << (DATA_W - 1));
            end
            ST_PARITY: begin
                if (bit_end)
                    perr_nxt = (sampled_data != exp_parity(^shift_q, cfg_q.par_typ));
            end
            ST_STOP: begin
                if (bit_end) begin
                    serr_nxt = ~sampled_data;
                    // parity_error is already settled: it was written a full bit earlier
                    if (sampled_data && !parity_error) begin
                        p_data_nxt = shift_q;
                        dv_nxt     = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_based_on_prescale or negedge rst_n) begin
        if (!rst_n) begin
            data_sampler_enable <= 1'b0;
            shift_q             <= '0;
            P_DATA              <= '0;
            data_valid          <= 1'b0;
            parity_error        <= 1'b0;
            stop_error          <= 1'b0;
        end else begin
            data_sampler_enable <= (state_nxt != ST_IDLE);
            shift_q             <= shift_nxt;
            P_DATA              <= p_data_nxt;
            data_valid          <= dv_nxt;
            parity_error        <= perr_nxt;
            stop_error          <= serr_nxt;
        end
    end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Sequencing controller for the UART receiver. Detects the start-bit falling edge on `RX_IN` and runs a per-bit edge counter that drives `Data_Sampler` (`data_sampler_enable`, `edge_count`). It consumes the majority-voted `sampled_data` once per bit and walks the frame through start, data, parity and stop. It deserializes LSB-first into `P_DATA` and flags parity and stop errors; it sits between the RX pin and the system-side byte interface.

## Interface
- `DATA_W`, default 8: data bits per frame.
- `clk_based_on_prescale`  in  1  oversampling clock, prescale ticks per bit.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `RX_IN`  in  1  serial line, idle high.
- `prescale`  in  6  oversampling ratio; legal values are even, 8..62; 8/16/32 are verified.
- `PAR_EN`  in  1  parity bit present.
- `PAR_TYP`  in  1  0 = even, 1 = odd.
- `sampled_data`  in  1  majority result from `Data_Sampler`.
- `data_sampler_enable`  out  1  sampler enable; high in every non-IDLE state.
- `edge_count`  out  6  oversample index within the current bit, 0..prescale-1.
- `P_DATA`  out  DATA_W  last received byte.
- `data_valid`  out  1  one-cycle pulse marking a good frame.
- `parity_error`  out  1  parity mismatch on the last frame.
- `stop_error`  out  1  stop bit sampled low on the last frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `RX_IN`=0 → START; `edge_count`←0, `bit_count`←0.
  - `parity_error` and `stop_error` clear on this transition.
- **Edge counter:**
  - Increments every cycle outside IDLE.
  - At prescale-1 it wraps to 0. This is the bit-end cycle.
- **Sampler contract:**
  - `Data_Sampler` samples at prescale/2-1, prescale/2 and prescale/2+1.
  - `sampled_data` is guaranteed stable by the bit-end cycle.
  - The controller reads `sampled_data` only at the bit-end cycle.
- **START:** at bit-end → DATA (see Configuration for the glitch check).
- **DATA:**
  - At each bit-end, shift `sampled_data` into the MSB of the shift register (LSB-first frame).
  - `bit_count` increments.
  - After bit DATA_W-1: go to PARITY if `PAR_EN`, else STOP.
- **PARITY:** at bit-end, `parity_error` ← `sampled_data` ≠ (^shift XOR `PAR_TYP`).
- **STOP:**
  - At bit-end, `stop_error` ← ~`sampled_data`.
  - If neither error: `P_DATA`←shift and `data_valid`=1 for one cycle.
  - Go to IDLE.
- `P_DATA` holds until the next good frame.
- Errored frames leave `P_DATA` unchanged. Both error flags hold until the next start.
- `PAR_EN`, `PAR_TYP` and `prescale` are sampled only in IDLE and frozen per frame. Changes mid-frame are ignored.
- Reset mid-frame: immediately IDLE with all outputs at reset values; no `data_valid`.

## Timing
- All outputs are registered.
- Reset values: `data_sampler_enable`=0, `edge_count`=0, `P_DATA`=0, `data_valid`=0, `parity_error`=0, `stop_error`=0, state IDLE.
- Start detection:
  - `RX_IN` low at cycle t → state START and `data_sampler_enable`=1 at t+1.
  - `edge_count`=0 at t+1.
- Frame length from t+1: (1 + DATA_W + PAR_EN + 1) × prescale cycles.
- `data_valid` and `P_DATA` update on the cycle after the STOP bit-end, together with the IDLE entry.
- Back-to-back frames:
  - The IDLE entry cycle already tests `RX_IN`.
  - The next start bit is detected with at most one cycle of skew.
- Error flags update on the cycle after the relevant bit-end.

## Configuration
- `UART_RX_START_GLITCH_EN`
  - Defined: at the START bit-end, `sampled_data`=1 is treated as a glitch. Return to IDLE with no flags and no `data_valid`.
  - Undefined: START always proceeds to DATA.

## Structure
- Shared package `uart_rx_pkg`:
  - State enum.
  - Parity type constants (`PAR_EVEN`=0, `PAR_ODD`=1).
  - `PRESCALE_W`=6.
- Natural sub-module: `uart_rx_edge_bit_counter` (edge counter plus `bit_count`, enable and wrap). The FSM, shift register and checks stay in the top.
- `Data_Sampler` is instantiated alongside, not inside.

## Test plan
- **Good frame.** prescale=8, PAR_EN=0, frame 0x A5 LSB-first, stop=1.
  - `data_valid` pulses once, 80 cycles after start entry.
  - `P_DATA`=0xA5, both errors 0.
- **Even parity.** PAR_EN=1, PAR_TYP=0, byte 0x03.
  - Parity bit 0 → `data_valid`, `P_DATA`=0x03.
  - Parity bit 1 → `parity_error`=1, no `data_valid`, `P_DATA` unchanged.
- **Stop error.** Stop bit driven 0, byte 0x55.
  - `stop_error`=1, no `data_valid`.
  - Flag clears on the next start edge.
- **Start glitch.** With `UART_RX_START_GLITCH_EN`, RX_IN low for 2 cycles only at prescale=16.
  - Returns to IDLE after 16 cycles; no flags.
  - Without the macro, the frame proceeds.
- **Back-to-back.** prescale=32, PAR_EN=1/odd, frames 0x00 then 0xFF with no idle gap.
  - Two `data_valid` pulses 352±1 cycles apart, correct bytes.
- **Reset mid-frame.** `rst_n` low during DATA bit 4.
  - All outputs 0 immediately.
  - The following clean frame 0x3C is received correctly.
